// File: rtl/byte_deser_pkg.sv
// Shared definitions for the byte deserializer: FSM states, parameter defaults,
// UART control codes and the LEN-byte validity check.
package byte_deser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_HOLD    = 2'd2
   } state_e;

   localparam int unsigned MAX_BYTES_DEF      = 32;
   localparam int unsigned CNT_W_DEF          = 6;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 100000;

   localparam logic [7:0] CMD_RESET = 8'hFF;
   localparam logic [7:0] CMD_TEST  = 8'hFE;

   // A LEN byte is usable only when it names 1..max_bytes payload bytes.
   function automatic logic len_ok(input logic [7:0] b, input int unsigned max_bytes);
      return (b != 8'd0) && (32'(b) <= max_bytes);
   endfunction

endpackage

// File: rtl/byte_deser_rx_strobe_sync.sv
// Brings the uart byte-ready level into the clk domain and turns each rising
// edge into a single-cycle strobe; a level held high never re-triggers.
module rx_strobe_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic rdy_i,
   output logic strobe_c_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= rdy_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign strobe_c_o = sync_q & ~prev_q;

endmodule

// File: rtl/byte_deser.sv
// Assembles length-prefixed frames from the uart byte stream and presents each
// frame as one wide word with a byte count and a valid/ready handshake.
module byte_deser
   import byte_deser_pkg::*;
#(
   parameter int unsigned MAX_BYTES      = MAX_BYTES_DEF,
   parameter int unsigned CNT_W          = CNT_W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [7:0]             rx_d,
   input  logic                   rx_rdy,
   output logic [MAX_BYTES*8-1:0] dout,
   output logic [CNT_W-1:0]       dout_bytecount,
   output logic                   dout_valid,
   input  logic                   dout_ready,
   output logic                   err_len,
   output logic                   err_timeout,
   output logic                   err_overrun
);

   localparam int unsigned DW    = MAX_BYTES * 8;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   len_q, cnt_q, bytecount_q;
   logic [TMO_W-1:0]   tmo_q;
   logic [DW-1:0]      buf_q, dout_q;
   logic               valid_q, err_len_q, err_tmo_q, err_ovr_q;

   logic strobe_c, last_c, tmo_exp_c, free_c;
   logic start_c, wr_c, tmo_inc_c, load_c, err_len_c, err_tmo_c, err_ovr_c;

   rx_strobe_sync u_sync (
      .clk        (clk),
      .rst_n      (reset_n),
      .rdy_i      (rx_rdy),
      .strobe_c_o (strobe_c)
   );

   assign last_c    = (cnt_q + CNT_W'(1)) == len_q;
   assign tmo_exp_c = tmo_q == TMO_W'(TIMEOUT_CYCLES - 1);
   assign free_c    = ~valid_q | dout_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (strobe_c && len_ok(rx_d, MAX_BYTES)) state_d = ST_PAYLOAD;
         ST_PAYLOAD: begin
            if (strobe_c) begin
               if (last_c) state_d = ST_HOLD;
            end else if (tmo_exp_c) begin
               state_d = ST_IDLE;
            end
         end
         ST_HOLD:    if (free_c) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Datapath controls; a strobe beats a timeout expiring in the same cycle.
   always_comb begin
      start_c   = 1'b0;
      wr_c      = 1'b0;
      tmo_inc_c = 1'b0;
      load_c    = 1'b0;
      err_len_c = 1'b0;
      err_tmo_c = 1'b0;
      err_ovr_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (strobe_c) begin
               if (len_ok(rx_d, MAX_BYTES)) start_c   = 1'b1;
               else                         err_len_c = 1'b1;
            end
         end
         ST_PAYLOAD: begin
            if (strobe_c)       wr_c      = 1'b1;
            else if (tmo_exp_c) err_tmo_c = 1'b1;
            else                tmo_inc_c = 1'b1;
         end
         ST_HOLD: begin
            load_c    = free_c;
            err_ovr_c = strobe_c;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_q <= '0;
         cnt_q <= '0;
         tmo_q <= '0;
         buf_q <= '0;
      end else if (start_c) begin
         len_q <= CNT_W'(rx_d);
         cnt_q <= '0;
         tmo_q <= '0;
         buf_q <= '0;
      end else if (wr_c) begin
         buf_q[int'(cnt_q)*8 +: 8] <= rx_d;
         cnt_q <= cnt_q + CNT_W'(1);
         tmo_q <= '0;
      end else if (err_tmo_c) begin
         cnt_q <= '0;
         tmo_q <= '0;
         buf_q <= '0;
      end else if (tmo_inc_c) begin
         tmo_q <= tmo_q + TMO_W'(1);
      end
   end

   // Output register: a load in the accept cycle keeps valid high (no bubble).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout_q      <= '0;
         bytecount_q <= '0;
         valid_q     <= 1'b0;
      end else if (load_c) begin
         dout_q      <= buf_q;
         bytecount_q <= len_q;
         valid_q     <= 1'b1;
      end else if (dout_ready) begin
         valid_q     <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_len_q <= 1'b0;
         err_tmo_q <= 1'b0;
         err_ovr_q <= 1'b0;
      end else begin
         err_len_q <= err_len_c;
         err_tmo_q <= err_tmo_c;
         err_ovr_q <= err_ovr_c;
      end
   end

   assign dout           = dout_q;
   assign dout_bytecount = bytecount_q;
   assign dout_valid     = valid_q;
   assign err_len        = err_len_q;
   assign err_timeout    = err_tmo_q;
   assign err_overrun    = err_ovr_q;

endmodule

// File: tb/tb_byte_deser.sv
// Bench for byte_deser: directed vector table, multi-cycle corner sequences and
// a randomized byte stream checked against a frame-parsing reference model.
module tb_byte_deser;

   localparam int unsigned MAXB = 32;
   localparam int unsigned CW   = 6;
   localparam int unsigned TMO  = 200;
   localparam int unsigned DW   = MAXB * 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [7:0]    rx_d;
   logic          rx_rdy;
   logic [DW-1:0] dout;
   logic [CW-1:0] dout_bytecount;
   logic          dout_valid;
   logic          dout_ready;
   logic          err_len, err_timeout, err_overrun;

   logic rdy_dir, rdy_rand, mon_en;
   assign dout_ready = mon_en ? rdy_rand : rdy_dir;

   int n_tests = 0, n_fail = 0;
   int n_elen = 0, n_etmo = 0, n_eovr = 0, n_excl = 0;

   logic [DW-1:0] cap_d[$];
   int            cap_n[$];
   logic [DW-1:0] exp_d[$];
   int            exp_n[$];
   logic [7:0]    stream[$];

   typedef struct {
      int          n;
      logic [31:0] bytes;
      logic [31:0] exp_dout;
      int          exp_cnt;
      int          exp_elen;
   } vec_t;
   vec_t vecs[7];

   byte_deser #(.MAX_BYTES(MAXB), .CNT_W(CW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .rx_d           (rx_d),
      .rx_rdy         (rx_rdy),
      .dout           (dout),
      .dout_bytecount (dout_bytecount),
      .dout_valid     (dout_valid),
      .dout_ready     (dout_ready),
      .err_len        (err_len),
      .err_timeout    (err_timeout),
      .err_overrun    (err_overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Error-pulse counters and the randomized consumer, sampled after each edge.
   initial begin
      int lows;
      lows = 0;
      forever begin
         @(posedge clk);
         #1;
         if (err_len)     n_elen++;
         if (err_timeout) n_etmo++;
         if (err_overrun) n_eovr++;
         if (int'(err_len) + int'(err_timeout) + int'(err_overrun) > 1) n_excl++;
         if (mon_en) begin
            rdy_rand = (lows >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
            lows = rdy_rand ? 0 : lows + 1;
            if (dout_valid && rdy_rand) begin
               cap_d.push_back(dout);
               cap_n.push_back(int'(dout_bytecount));
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int hi = 4, input int lo = 4);
      rx_d   = b;
      rx_rdy = 1'b1;
      tick(hi);
      rx_rdy = 1'b0;
      tick(lo);
   endtask

   task automatic wait_valid(input int budget);
      for (int i = 0; i < budget && !dout_valid; i++) tick();
   endtask

   task automatic accept();
      rdy_dir = 1'b1;
      tick();
      rdy_dir = 1'b0;
   endtask

   initial begin
      int e0, e1, e2;
      logic [DW-1:0] big;
      rx_d = 8'h00; rx_rdy = 1'b0; rdy_dir = 1'b0; rdy_rand = 1'b0; mon_en = 1'b0;

      #1;
      chk("reset_dout", dout, '0);
      chk("reset_ctl", DW'({dout_bytecount, dout_valid, err_len, err_timeout, err_overrun}), '0);
      tick(3);
      reset_n = 1'b1;
      tick(2);

      vecs[0] = '{4, 32'hC3B2A103, 32'h00C3B2A1, 3, 0};
      vecs[1] = '{1, 32'h00000000, 32'h0, 0, 1};
      vecs[2] = '{1, 32'h00000021, 32'h0, 0, 1};
      vecs[3] = '{1, 32'h000000FE, 32'h0, 0, 1};
      vecs[4] = '{1, 32'h000000FF, 32'h0, 0, 1};
      vecs[5] = '{2, 32'h00005A01, 32'h0000005A, 1, 0};
      vecs[6] = '{3, 32'h00BBAA02, 32'h0000BBAA, 2, 0};

      for (int v = 0; v < 7; v++) begin
         e0 = n_elen;
         for (int j = 0; j < vecs[v].n; j++) send_byte(vecs[v].bytes[j*8 +: 8]);
         if (vecs[v].exp_cnt > 0) begin
            wait_valid(20);
            chk($sformatf("vec%0d_valid", v), DW'(dout_valid), DW'(1));
            chk($sformatf("vec%0d_dout", v), dout, DW'(vecs[v].exp_dout));
            chk($sformatf("vec%0d_cnt", v), DW'(dout_bytecount), DW'(vecs[v].exp_cnt));
            tick(3);
            chk($sformatf("vec%0d_hold", v), DW'({dout_valid, dout[31:0]}), DW'({1'b1, vecs[v].exp_dout}));
            accept();
         end
         chk($sformatf("vec%0d_valid_low", v), DW'(dout_valid), '0);
         chk($sformatf("vec%0d_err_len", v), DW'(n_elen - e0), DW'(vecs[v].exp_elen));
      end

      // Payload gap longer than the timeout aborts the frame.
      e0 = n_etmo;
      send_byte(8'd4); send_byte(8'h10); send_byte(8'h20);
      tick(TMO + 20);
      chk("tmo_pulse", DW'(n_etmo - e0), DW'(1));
      chk("tmo_no_valid", DW'(dout_valid), '0);
      send_byte(8'd1); send_byte(8'h5A);
      wait_valid(20);
      chk("tmo_next_dout", dout, DW'(8'h5A));
      chk("tmo_next_cnt", DW'(dout_bytecount), DW'(1));
      accept();

      // Blocked output: second frame waits, extra byte overruns, then back-to-back.
      e1 = n_eovr; e2 = n_elen;
      send_byte(8'd1); send_byte(8'h11);
      wait_valid(20);
      chk("ovr_f1", dout, DW'(8'h11));
      send_byte(8'd1); send_byte(8'h22);
      send_byte(8'h33);
      chk("ovr_pulse", DW'(n_eovr - e1), DW'(1));
      chk("ovr_errlen", DW'(n_elen - e2), '0);
      chk("ovr_still_f1", DW'({dout_valid, dout[7:0]}), DW'({1'b1, 8'h11}));
      rdy_dir = 1'b1;
      tick();
      chk("ovr_b2b_f2", DW'({dout_valid, dout[7:0]}), DW'({1'b1, 8'h22}));
      tick();
      rdy_dir = 1'b0;
      chk("ovr_drained", DW'(dout_valid), '0);

      // Long rx_rdy levels must give exactly one strobe per byte.
      e1 = n_eovr; e2 = n_elen;
      send_byte(8'd32, 50);
      big = '0;
      for (int i = 0; i < 32; i++) begin
         send_byte(8'(i), 50);
         big[i*8 +: 8] = 8'(i);
      end
      wait_valid(20);
      chk("long_dout", dout, big);
      chk("long_cnt", DW'(dout_bytecount), DW'(32));
      chk("long_errs", DW'((n_eovr - e1) + (n_elen - e2)), '0);
      accept();

      // Reset mid-payload clears everything at once.
      send_byte(8'd1); send_byte(8'h77);
      wait_valid(20);
      send_byte(8'd4); send_byte(8'h01);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_dout", dout, '0);
      chk("rst_mid_ctl", DW'({dout_bytecount, dout_valid, err_len, err_timeout, err_overrun}), '0);
      tick(2);
      reset_n = 1'b1;
      tick(2);
      send_byte(8'd2); send_byte(8'hAA); send_byte(8'hBB);
      wait_valid(20);
      chk("rst_after_dout", dout, DW'(16'hBBAA));
      chk("rst_after_cnt", DW'(dout_bytecount), DW'(2));
      accept();

      // Randomized stream against the frame-parsing model.
      e0 = n_elen; e1 = n_etmo; e2 = n_eovr;
      mon_en = 1'b1;
      for (int f = 0; f < 25; f++) begin
         logic [7:0] b;
         if ($urandom_range(0, 7) == 0)
            b = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(33, 255));
         else
            b = 8'($urandom_range(1, 32));
         stream.push_back(b);
         send_byte(b, $urandom_range(3, 6), $urandom_range(4, 6));
         if (b >= 8'd1 && b <= 8'(MAXB)) begin
            for (int k = 0; k < int'(b); k++) begin
               logic [7:0] p;
               p = 8'($urandom);
               stream.push_back(p);
               send_byte(p, $urandom_range(3, 6), $urandom_range(4, 6));
            end
         end
      end
      tick(20);
      mon_en = 1'b0;

      begin
         int i, bad;
         logic [DW-1:0] d;
         i = 0; bad = 0;
         while (i < stream.size()) begin
            int len;
            len = int'(stream[i]);
            i++;
            if (len >= 1 && len <= int'(MAXB)) begin
               d = '0;
               for (int k = 0; k < len; k++) begin
                  d[k*8 +: 8] = stream[i];
                  i++;
               end
               exp_d.push_back(d);
               exp_n.push_back(len);
            end else begin
               bad++;
            end
         end
         chk("rand_nframes", DW'(cap_d.size()), DW'(exp_d.size()));
         for (int k = 0; k < exp_d.size() && k < cap_d.size(); k++) begin
            chk($sformatf("rand_f%0d_dout", k), cap_d[k], exp_d[k]);
            chk($sformatf("rand_f%0d_cnt", k), DW'(cap_n[k]), DW'(exp_n[k]));
         end
         chk("rand_err_len", DW'(n_elen - e0), DW'(bad));
         chk("rand_err_other", DW'((n_etmo - e1) + (n_eovr - e2)), '0);
      end

      chk("err_exclusive", DW'(n_excl), '0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
